// File: rtl/fpu_issue.sv
// CPU-side FPU request initiator: issues a one-hot opcode pulse, waits for the FPU
// result under a watchdog, and hands the buffered result to writeback via valid/ready.
module fpu_issue #(
    parameter int TIMEOUT = 64
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic [9:0]  fpu_opcode,
    output logic [31:0] fpu_x1,
    output logic [31:0] fpu_x2,
    input  logic [31:0] fpu_y,
    input  logic        fpu_ovf,
    input  logic        fpu_unf,
    input  logic        fpu_out_valid,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_ovf,
    output logic        wb_unf,
    output logic        wb_err,
    output logic [1:0]  fflags,
    input  logic        fflags_clr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // The counter is cleared in ISSUE, so the WAIT cycle that sees this value is
    // the last one allowed before the watchdog fires.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);

    state_t      state_reg, state_next;
    logic [9:0]  opcode_reg, opcode_next;
    logic [31:0] x1_reg, x1_next;
    logic [31:0] x2_reg, x2_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        wb_valid_reg, wb_valid_next;
    logic [4:0]  wb_rd_reg, wb_rd_next;
    logic [31:0] wb_data_reg, wb_data_next;
    logic        wb_ovf_reg, wb_ovf_next;
    logic        wb_unf_reg, wb_unf_next;
    logic        wb_err_reg, wb_err_next;
    logic [1:0]  fflags_reg, fflags_next;

    logic [9:0]  op_onehot;
    logic        op_legal;
    logic        capture;

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_onehot
            assign op_onehot[gi] = (req_op == 4'(gi));
        end
    endgenerate

    assign op_legal = (req_op < 4'd10);

    always_comb begin
        state_next    = state_reg;
        opcode_next   = '0;
        x1_next       = x1_reg;
        x2_next       = x2_reg;
        cnt_next      = cnt_reg;
        wb_valid_next = wb_valid_reg;
        wb_rd_next    = wb_rd_reg;
        wb_data_next  = wb_data_reg;
        wb_ovf_next   = wb_ovf_reg;
        wb_unf_next   = wb_unf_reg;
        wb_err_next   = wb_err_reg;
        capture       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    wb_rd_next = req_rd;
                    if (op_legal) begin
                        x1_next     = req_rs1;
                        x2_next     = req_rs2;
                        opcode_next = op_onehot;
                        state_next  = S_ISSUE;
                    end else begin
                        wb_data_next  = '0;
                        wb_ovf_next   = 1'b0;
                        wb_unf_next   = 1'b0;
                        wb_err_next   = 1'b1;
                        wb_valid_next = 1'b1;
                        state_next    = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                cnt_next = '0;
                if (fpu_out_valid) begin
                    capture = 1'b1;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_next = cnt_reg + 8'd1;
                if (fpu_out_valid) begin
                    capture = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    wb_data_next  = '0;
                    wb_ovf_next   = 1'b0;
                    wb_unf_next   = 1'b0;
                    wb_err_next   = 1'b1;
                    wb_valid_next = 1'b1;
                    state_next    = S_RESP;
                end
            end
            S_RESP: begin
                if (wb_ready) begin
                    wb_valid_next = 1'b0;
                    state_next    = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (capture) begin
            wb_data_next  = fpu_y;
            wb_ovf_next   = fpu_ovf;
            wb_unf_next   = fpu_unf;
            wb_err_next   = 1'b0;
            wb_valid_next = 1'b1;
            state_next    = S_RESP;
        end

        // A clear coinciding with a capture keeps only the freshly captured bits.
        if (capture) begin
            fflags_next = fflags_clr ? {fpu_ovf, fpu_unf}
                                     : (fflags_reg | {fpu_ovf, fpu_unf});
        end else if (fflags_clr) begin
            fflags_next = '0;
        end else begin
            fflags_next = fflags_reg;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            opcode_reg   <= '0;
            x1_reg       <= '0;
            x2_reg       <= '0;
            cnt_reg      <= '0;
            wb_valid_reg <= 1'b0;
            wb_rd_reg    <= '0;
            wb_data_reg  <= '0;
            wb_ovf_reg   <= 1'b0;
            wb_unf_reg   <= 1'b0;
            wb_err_reg   <= 1'b0;
            fflags_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            opcode_reg   <= opcode_next;
            x1_reg       <= x1_next;
            x2_reg       <= x2_next;
            cnt_reg      <= cnt_next;
            wb_valid_reg <= wb_valid_next;
            wb_rd_reg    <= wb_rd_next;
            wb_data_reg  <= wb_data_next;
            wb_ovf_reg   <= wb_ovf_next;
            wb_unf_reg   <= wb_unf_next;
            wb_err_reg   <= wb_err_next;
            fflags_reg   <= fflags_next;
        end
    end

    // Gating with rst keeps the FPU from seeing an opcode during the first reset cycle.
    assign fpu_opcode = rst ? 10'd0 : opcode_reg;
    assign req_ready  = (state_reg == S_IDLE);
    assign fpu_x1     = x1_reg;
    assign fpu_x2     = x2_reg;
    assign wb_valid   = wb_valid_reg;
    assign wb_rd      = wb_rd_reg;
    assign wb_data    = wb_data_reg;
    assign wb_ovf     = wb_ovf_reg;
    assign wb_unf     = wb_unf_reg;
    assign wb_err     = wb_err_reg;
    assign fflags     = fflags_reg;

endmodule

// File: tb/tb_fpu_issue.sv
// Self-checking bench for fpu_issue: scenario tasks plus randomized requests checked
// against a cycle-count reference model of the request/response protocol.
module tb_fpu_issue;

    localparam int TO = 8;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic [4:0]  req_rd = '0;
    logic [9:0]  fpu_opcode;
    logic [31:0] fpu_x1, fpu_x2;
    logic [31:0] fpu_y = '0;
    logic        fpu_ovf = 1'b0;
    logic        fpu_unf = 1'b0;
    logic        fpu_out_valid = 1'b0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ovf, wb_unf, wb_err;
    logic [1:0]  fflags;
    logic        fflags_clr = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [1:0] model_fflags = 2'b00;

    fpu_issue #(.TIMEOUT(TO)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .fpu_opcode(fpu_opcode), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
        .fpu_y(fpu_y), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf), .fpu_out_valid(fpu_out_valid),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_ovf(wb_ovf), .wb_unf(wb_unf), .wb_err(wb_err),
        .fflags(fflags), .fflags_clr(fflags_clr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // One request end to end. Expected timing comes from the protocol rules:
    // result strobe in cycle 1+lat is captured iff it lands no later than cycle TO,
    // otherwise the watchdog answers in cycle TO+1.
    task automatic run_op(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [4:0] rd, input int lat, input logic [31:0] y,
                          input logic ovf, input logic unf, input bit clr_cap,
                          input int bp, input bit hold_req);
        bit          legal = (op < 4'd10);
        bit          cap = legal && (lat <= TO - 1);
        int          exp_cyc = !legal ? 1 : (cap ? lat + 2 : TO + 1);
        logic [9:0]  one = 10'd1;
        logic [9:0]  exp_oc;
        logic [31:0] exp_data = cap ? y : 32'd0;
        logic        exp_ovf = cap ? ovf : 1'b0;
        logic        exp_unf = cap ? unf : 1'b0;
        logic        exp_err = !cap;
        logic [53:0] got_v, exp_v;

        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_idle: got %b expected 1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
        fpu_out_valid = 1'b0; fflags_clr = 1'b0; wb_ready = 1'b0;
        step();
        req_valid = 1'b0; req_op = 4'($urandom); req_rs1 = $urandom; req_rs2 = $urandom;
        req_rd = 5'($urandom);

        for (int c = 1; c <= exp_cyc; c++) begin
            exp_oc = (legal && c == 1) ? (one << op) : 10'd0;
            checks++;
            if (fpu_opcode !== exp_oc) begin
                errors++;
                $display("FAIL opcode op=%0d cyc=%0d: got %h expected %h", op, c, fpu_opcode, exp_oc);
            end
            checks++;
            if (wb_valid !== (c == exp_cyc)) begin
                errors++;
                $display("FAIL wb_valid_timing op=%0d cyc=%0d: got %b expected %b", op, c, wb_valid, c == exp_cyc);
            end
            if (legal && c == 1) begin
                checks++;
                if ({fpu_x1, fpu_x2} !== {rs1, rs2}) begin
                    errors++;
                    $display("FAIL operands: got %h/%h expected %h/%h", fpu_x1, fpu_x2, rs1, rs2);
                end
            end
            if (c < exp_cyc) begin
                fpu_out_valid = cap && (c == lat + 1);
                fpu_y   = fpu_out_valid ? y : $urandom;
                fpu_ovf = fpu_out_valid ? ovf : 1'($urandom);
                fpu_unf = fpu_out_valid ? unf : 1'($urandom);
                fflags_clr = clr_cap && fpu_out_valid;
                step();
                fpu_out_valid = 1'b0;
                fflags_clr = 1'b0;
            end
        end

        if (cap) model_fflags = clr_cap ? {ovf, unf} : (model_fflags | {ovf, unf});
        exp_v = {1'b1, rd, exp_data, exp_ovf, exp_unf, exp_err, model_fflags, 1'b0, 10'd0};
        got_v = {wb_valid, wb_rd, wb_data, wb_ovf, wb_unf, wb_err, fflags, req_ready, fpu_opcode};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL wb_fields op=%0d: got %h expected %h", op, got_v, exp_v);
        end

        // Writeback stall: stray strobes must not disturb the held response or flags.
        for (int b = 0; b < bp; b++) begin
            req_valid = hold_req;
            if (hold_req) begin
                req_op = 4'd7; req_rs1 = 32'hBF80_0000; req_rs2 = 32'd0; req_rd = 5'd3;
            end
            fpu_out_valid = (b % 2 == 1) ? 1'b1 : 1'($urandom);
            fpu_ovf = 1'b1; fpu_unf = 1'b1; fpu_y = $urandom;
            step();
            fpu_out_valid = 1'b0;
            got_v = {wb_valid, wb_rd, wb_data, wb_ovf, wb_unf, wb_err, fflags, req_ready, fpu_opcode};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL wb_stall b=%0d: got %h expected %h", b, got_v, exp_v);
            end
        end

        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        checks++;
        if ({wb_valid, req_ready, fpu_opcode} !== {1'b0, 1'b1, 10'd0}) begin
            errors++;
            $display("FAIL handshake_idle: got wb_valid=%b req_ready=%b opcode=%h expected 0/1/000",
                     wb_valid, req_ready, fpu_opcode);
        end
        $display("txn op=%0d rd=%0d lat=%0d wb_cycle=%0d data=%h err=%b fflags=%b",
                 op, rd, lat, exp_cyc, exp_data, exp_err, model_fflags);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_op = 4'd2; fpu_out_valid = 1'b1; fpu_ovf = 1'b1;
        fflags_clr = 1'b0;
        step(); step();
        checks++;
        if ({req_ready, fpu_opcode, fpu_x1, fpu_x2, wb_valid, wb_rd, wb_data, wb_ovf, wb_unf, wb_err, fflags}
            !== {1'b1, 10'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_values: got ready=%b opc=%h x1=%h x2=%h wbv=%b rd=%h data=%h flags=%b%b%b fflags=%b",
                     req_ready, fpu_opcode, fpu_x1, fpu_x2, wb_valid, wb_rd, wb_data, wb_ovf, wb_unf, wb_err, fflags);
        end
        req_valid = 1'b0; fpu_out_valid = 1'b0; fpu_ovf = 1'b0;
        rst = 1'b0;
        model_fflags = 2'b00;
        step();
    endtask

    task automatic test_fadd();
        run_op(4'd0, 32'h3F80_0000, 32'h4000_0000, 5'd5, 3, 32'h4040_0000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_sticky_flags();
        run_op(4'd2, 32'h7F00_0000, 32'h7F00_0000, 5'd1, 2, 32'h7F80_0000, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        run_op(4'd3, 32'h0080_0000, 32'h7F00_0000, 5'd2, 4, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        run_op(4'd2, 32'h7F00_0000, 32'h4000_0000, 5'd3, 1, 32'h7F80_0000, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_illegal();
        run_op(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7, 0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 2, 1'b0);
    endtask

    task automatic test_timeout();
        run_op(4'd3, 32'h3F80_0000, 32'h0, 5'd9, 100, 32'h0, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        run_op(4'd1, 32'h4000_0000, 32'h3F80_0000, 5'd10, TO - 1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        run_op(4'd1, 32'h4000_0000, 32'h3F80_0000, 5'd11, TO, 32'h3F80_0000, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op(4'd2, 32'h4000_0000, 32'h4040_0000, 5'd12, 2, 32'h40C0_0000, 1'b0, 1'b0, 1'b0, 10, 1'b1);
        run_op(4'd7, 32'hBF80_0000, 32'd0, 5'd3, 1, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        req_valid = 1'b1; req_op = 4'd4; req_rs1 = 32'h4080_0000; req_rd = 5'd6;
        step();
        req_valid = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        model_fflags = 2'b00;
        checks++;
        if ({req_ready, fpu_opcode, wb_valid, fpu_x1, fflags} !== {1'b1, 10'd0, 1'b0, 32'd0, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid_wait: got ready=%b opc=%h wbv=%b x1=%h fflags=%b",
                     req_ready, fpu_opcode, wb_valid, fpu_x1, fflags);
        end
        rst = 1'b0;
        fpu_out_valid = 1'b1; fpu_ovf = 1'b1; fpu_y = 32'h4000_0000;
        step();
        fpu_out_valid = 1'b0; fpu_ovf = 1'b0;
        checks++;
        if ({wb_valid, fflags, req_ready} !== {1'b0, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL late_result_ignored: got wbv=%b fflags=%b ready=%b expected 0/00/1",
                     wb_valid, fflags, req_ready);
        end
        run_op(4'd7, 32'hBF80_0000, 32'd0, 5'd4, 2, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Reset landing in the ISSUE cycle must mask the opcode pulse immediately.
        req_valid = 1'b1; req_op = 4'd0;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (fpu_opcode !== 10'd0) begin
            errors++;
            $display("FAIL opcode_in_reset: got %h expected 000", fpu_opcode);
        end
        step();
        rst = 1'b0;
        model_fflags = 2'b00;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [3:0] op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            run_op(op, $urandom, $urandom, 5'($urandom), $urandom_range(0, TO + 1), $urandom,
                   1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_fadd();
        test_sticky_flags();
        test_illegal();
        test_timeout();
        test_backpressure();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
